// File: rtl/mm_tx_if.sv
// Data-path bundle between the user source and the mm_tx serializer:
// user bits with a valid/ready handshake, and the registered DAC symbols.
interface mm_tx_if #(
  parameter int Ndac = 8,
  parameter int Nti  = 1
);
  logic [Nti-1:0]         data_in;
  logic                   data_valid;
  logic                   data_ready;
  logic signed [Ndac-1:0] dout [Nti];

  modport master (
    output data_in,
    output data_valid,
    input  data_ready,
    input  dout
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready,
    output dout
  );
endinterface

// File: rtl/mm_tx.sv
// Multi-lane link transmitter: IDLE -> PREAMBLE (1010...) -> TRAIN (PRBS7) ->
// DATA (user bits, PRBS fill on underflow). Each bit becomes a +/-1 symbol
// shaped by a 2-tap FFE (main + post cursor) and saturated to the DAC range.
module mm_tx #(
  parameter int Ndac   = 8,
  parameter int Nti    = 1,
  parameter int Ntrain = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic [Ntrain-1:0]      train_len,
  input  logic signed [Ndac-1:0] amp,
  input  logic signed [Ndac-1:0] post,
  output logic [1:0]             state,
  output logic [7:0]             underflow_cnt,
  mm_tx_if.slave                 link
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    TRAIN    = 2'd2,
    DATA     = 2'd3
  } state_t;

  localparam logic [6:0] PRBS_SEED = 7'h7F;
  // Symbol sums are formed two bits wider than the DAC so that even
  // -(-2^(Ndac-1)) + -(-2^(Ndac-1)) cannot wrap before saturation.
  localparam logic signed [Ndac+1:0] SYM_MAX = (Ndac+2)'((1 << (Ndac-1)) - 1);
  localparam logic signed [Ndac+1:0] SYM_MIN = (Ndac+2)'(-(1 << (Ndac-1)));

  state_t                 state_r, state_nxt;
  logic [Ntrain-1:0]      cnt_r, cnt_nxt;
  logic [Ntrain-1:0]      tlen_r, tlen_nxt;
  logic [6:0]             prbs_r, prbs_nxt, prbs_adv_s;
  logic [Nti-1:0]         prbs_bits_s, bits_s;
  logic [Nti:0]           hist_ext_s;
  logic                   hist_r, hist_nxt;
  logic                   parity_r, parity_nxt;
  logic                   zero_s, last_s;
  logic [7:0]             ucnt_r, ucnt_nxt;
  logic signed [Ndac-1:0] dout_r   [Nti];
  logic signed [Ndac-1:0] dout_nxt [Nti];

  // One FFE tap pair: +/-amp plus +/-post, clamped to the DAC range.
  function automatic logic signed [Ndac-1:0] ffe_sym(
    input logic                   cur,
    input logic                   prev,
    input logic signed [Ndac-1:0] a_w,
    input logic signed [Ndac-1:0] p_w
  );
    logic signed [Ndac+1:0] a_x, p_x, sum;
    a_x = (Ndac+2)'(a_w);
    p_x = (Ndac+2)'(p_w);
    if (!cur) begin
      a_x = -a_x;
    end else begin
      a_x = a_x;
    end
    if (!prev) begin
      p_x = -p_x;
    end else begin
      p_x = p_x;
    end
    sum = a_x + p_x;
    if (sum > SYM_MAX) begin
      ffe_sym = SYM_MAX[Ndac-1:0];
    end else if (sum < SYM_MIN) begin
      ffe_sym = SYM_MIN[Ndac-1:0];
    end else begin
      ffe_sym = sum[Ndac-1:0];
    end
  endfunction

  assign last_s          = (cnt_r == (tlen_r - Ntrain'(1)));
  assign link.data_ready = (state_r == DATA) && !stop;
  assign link.dout       = dout_r;
  assign state           = state_r;
  assign underflow_cnt   = ucnt_r;

  // Run the PRBS7 forward Nti steps; lane i gets the i-th new bit.
  always_comb begin
    logic [6:0] q;
    q           = prbs_r;
    prbs_bits_s = '0;
    for (int i = 0; i < Nti; i++) begin
      prbs_bits_s[i] = q[6] ^ q[5];
      q              = {q[5:0], q[6] ^ q[5]};
    end
    prbs_adv_s = q;
  end

  // Next-state and per-cycle bit selection for the link phases.
  always_comb begin
    state_nxt  = state_r;
    cnt_nxt    = cnt_r;
    tlen_nxt   = tlen_r;
    prbs_nxt   = prbs_r;
    parity_nxt = parity_r;
    ucnt_nxt   = ucnt_r;
    bits_s     = '0;
    zero_s     = 1'b1;
    case (state_r)
      IDLE: begin
        if (start && !stop) begin
          prbs_nxt = PRBS_SEED;
          if (train_len != '0) begin
            state_nxt  = PREAMBLE;
            cnt_nxt    = '0;
            tlen_nxt   = train_len;
            parity_nxt = 1'b1;
          end else begin
            state_nxt = DATA;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      PREAMBLE: begin
        zero_s = 1'b0;
        for (int i = 0; i < Nti; i++) begin
          bits_s[i] = parity_r ^ 1'(i % 2);
        end
        parity_nxt = parity_r ^ 1'(Nti % 2);
        if (last_s) begin
          state_nxt = TRAIN;
          cnt_nxt   = '0;
          tlen_nxt  = train_len;
        end else begin
          cnt_nxt = cnt_r + Ntrain'(1);
        end
      end
      TRAIN: begin
        zero_s   = 1'b0;
        bits_s   = prbs_bits_s;
        prbs_nxt = prbs_adv_s;
        if (last_s) begin
          state_nxt = DATA;
        end else begin
          cnt_nxt = cnt_r + Ntrain'(1);
        end
      end
      DATA: begin
        if (stop) begin
          zero_s = 1'b1;
        end else if (link.data_valid) begin
          zero_s = 1'b0;
          bits_s = link.data_in;
        end else begin
          zero_s   = 1'b0;
          bits_s   = prbs_bits_s;
          prbs_nxt = prbs_adv_s;
          if (ucnt_r != 8'hFF) begin
            ucnt_nxt = ucnt_r + 8'd1;
          end else begin
            ucnt_nxt = ucnt_r;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (stop) begin
      state_nxt = IDLE;
    end else begin
      state_nxt = state_nxt;
    end
  end

  // FFE: lane 0's previous symbol comes from the last lane of the prior cycle.
  always_comb begin
    hist_ext_s = {bits_s, hist_r};
    for (int i = 0; i < Nti; i++) begin
      if (zero_s) begin
        dout_nxt[i] = '0;
      end else begin
        dout_nxt[i] = ffe_sym(hist_ext_s[i+1], hist_ext_s[i], amp, post);
      end
    end
    if (zero_s) begin
      hist_nxt = 1'b0;
    end else begin
      hist_nxt = bits_s[Nti-1];
    end
  end

  // State, phase counter, PRBS, history and registered DAC outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      tlen_r   <= '0;
      prbs_r   <= PRBS_SEED;
      hist_r   <= 1'b0;
      parity_r <= 1'b1;
      ucnt_r   <= 8'd0;
      for (int i = 0; i < Nti; i++) begin
        dout_r[i] <= '0;
      end
    end else begin
      state_r  <= state_nxt;
      cnt_r    <= cnt_nxt;
      tlen_r   <= tlen_nxt;
      prbs_r   <= prbs_nxt;
      hist_r   <= hist_nxt;
      parity_r <= parity_nxt;
      ucnt_r   <= ucnt_nxt;
      for (int i = 0; i < Nti; i++) begin
        dout_r[i] <= dout_nxt[i];
      end
    end
  end

endmodule
